// File: rtl/i2c_target_regs.sv
// I2C target bridging the uio SDA/SCL pins to the configuration register file:
// 7-bit address, 8-bit register pointer, auto-incrementing multi-byte reads/writes.
module i2c_target_regs #(
   parameter logic [6:0] I2C_ADDR    = 7'h70,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       sda_out,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy
);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      SUB,
      SUB_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RACK
   } state_t;

   localparam logic [2:0] SETTLE_N = 3'(SYNC_STAGES + 2);

   state_t                 state;
   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_d;
   logic                   sda_d;
   logic [2:0]             settle;
   logic                   armed;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_rise;
   logic                   scl_fall;
   logic                   start_det;
   logic                   stop_det;
   logic [7:0]             shreg;
   logic [7:0]             next_byte;
   logic [3:0]             bit_cnt;
   logic [7:0]             ptr;
   logic                   rw;
   logic                   ack_on;

   // Synchronizer chain plus history flop; settle masks the artificial edges
   // the chain produces while refilling with real pin levels after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
         settle   <= '0;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
         if (!armed) settle <= settle + 3'd1;
      end
   end

   assign armed     = (settle == SETTLE_N);
   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = armed & scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = armed & scl_s & scl_d & ~sda_d & sda_s;
   assign next_byte = {shreg[6:0], sda_s};

   assign rd_addr = ptr;
   assign sda_out = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sda_oe  <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= 8'h00;
         wr_data <= 8'h00;
         ptr     <= 8'h00;
         busy    <= 1'b0;
         shreg   <= 8'h00;
         bit_cnt <= 4'd0;
         rw      <= 1'b0;
         ack_on  <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         if (wr_en) ptr <= ptr + 8'd1;

         if (start_det) begin
            state   <= ADDR;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
            ack_on  <= 1'b0;
         end else if (stop_det) begin
            state  <= IDLE;
            busy   <= 1'b0;
            sda_oe <= 1'b0;
            ack_on <= 1'b0;
         end else begin
            unique case (state)
               IDLE: ;

               ADDR: if (scl_rise) begin
                  shreg <= next_byte;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= 4'd0;
                     if (next_byte[7:1] == I2C_ADDR) begin
                        rw    <= next_byte[0];
                        state <= ADDR_ACK;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end

               // ACK spans one full SCL period: pull on the first fall, let go on the next.
               ADDR_ACK, SUB_ACK, WDATA_ACK: if (scl_fall) begin
                  if (!ack_on) begin
                     sda_oe <= 1'b1;
                     ack_on <= 1'b1;
                     if (state == ADDR_ACK) busy <= 1'b1;
                  end else begin
                     ack_on  <= 1'b0;
                     bit_cnt <= 4'd0;
                     if (state == ADDR_ACK && rw) begin
                        shreg   <= rd_data;
                        sda_oe  <= ~rd_data[7];
                        ptr     <= ptr + 8'd1;
                        bit_cnt <= 4'd1;
                        state   <= RDATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= (state == ADDR_ACK) ? SUB : WDATA;
                     end
                  end
               end

               SUB: if (scl_rise) begin
                  shreg <= next_byte;
                  if (bit_cnt == 4'd7) begin
                     ptr     <= next_byte;
                     bit_cnt <= 4'd0;
                     state   <= SUB_ACK;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end

               WDATA: if (scl_rise) begin
                  shreg <= next_byte;
                  if (bit_cnt == 4'd7) begin
                     wr_en   <= 1'b1;
                     wr_addr <= ptr;
                     wr_data <= next_byte;
                     bit_cnt <= 4'd0;
                     state   <= WDATA_ACK;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end

               // bit_cnt counts bits already placed on the bus; the MSB went out on entry.
               RDATA: if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oe <= 1'b0;
                     state  <= RACK;
                  end else begin
                     sda_oe  <= ~shreg[6];
                     shreg   <= {shreg[6:0], 1'b0};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end

               RACK: begin
                  if (scl_rise) begin
                     if (sda_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end else begin
                        ack_on <= 1'b1;
                     end
                  end else if (scl_fall && ack_on) begin
                     ack_on  <= 1'b0;
                     shreg   <= rd_data;
                     sda_oe  <= ~rd_data[7];
                     ptr     <= ptr + 8'd1;
                     bit_cnt <= 4'd1;
                     state   <= RDATA;
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave) that answers the bit-banged controller transactions used to configure the dice design: 7-bit address, 8-bit register pointer, multi-byte writes and reads with pointer auto-increment.
- Sits between the uio SDA/SCL pins and the design's configuration register file.
- Exposes a one-cycle write strobe and a combinational read port to that register file.
- Drives SDA open-drain only: pulls low or releases.

Parameters:
- I2C_ADDR, 7'h70, target address compared against the first byte after START.
- SYNC_STAGES, 2, synchronizer flops on the SCL and SDA inputs (legal values 2..3).

Ports:
- clk  input  1  system clock; must be ≥10× the SCL frequency.
- rst  input  1  synchronous reset, active-high.
- scl_in  input  1  raw SCL pin level.
- sda_in  input  1  raw SDA pin level.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- sda_out  output  1  constant 0 (open-drain data value).
- wr_en  output  1  one-clk write strobe to the register file.
- wr_addr  output  8  register address for wr_en.
- wr_data  output  8  data byte for wr_en.
- rd_addr  output  8  current register pointer (combinational read address).
- rd_data  input  8  register contents at rd_addr, valid in the same cycle.
- busy  output  1  high from an addressed-ACK until STOP, a non-matching address, or a NACKed read.

Behaviour:
- Reset: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, pointer (rd_addr)=0, busy=0, state IDLE. Synchronizer flops reset to 1 (bus idle).
- Input path: SCL and SDA each pass through SYNC_STAGES flops plus one history flop. Edges are detected on the synchronized signals. Pin-to-event latency is SYNC_STAGES+1 clk.
- START: SDA falls while SCL is high. Detected in every state, including repeated START. Clears the bit counter and enters ADDR. Any in-progress byte is discarded and sda_oe is released.
- STOP: SDA rises while SCL is high. Detected in every state. Enters IDLE, sets busy=0 and releases sda_oe. A partial byte is discarded with no wr_en.
- Data is sampled on the SCL rising edge, MSB first. SDA is only changed by the target 1 clk after the synchronized SCL falling edge.
- States and transitions:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits. If bits[7:1]==I2C_ADDR → ADDR_ACK, rw latched from bit 0. Otherwise → IDLE with no ACK.
  - ADDR_ACK: on the falling edge after bit 8, set sda_oe=1. Release on the next falling edge. Then rw=0 → SUB, rw=1 → RDATA.
  - SUB: shift 8 bits. The pointer is loaded with the byte on the 8th rising edge. Then → SUB_ACK (ACK as above) → WDATA.
  - WDATA: shift 8 bits. On the 8th rising edge, for exactly one clk: wr_en=1, wr_addr=pointer, wr_data=byte. The pointer increments in the next clk. Then → WDATA_ACK → WDATA. Writes are unlimited.
  - RDATA:
    - On entry (the falling edge that ends an ACK), the shift register loads rd_data and the pointer increments.
    - Each bit is driven as sda_oe = ~bit, MSB first, on successive falling edges.
    - After 8 bits, release SDA → RACK.
  - RACK: sample SDA on the rising edge. 0 (ACK) → RDATA. 1 (NACK) → IDLE, busy=0, wait for START/STOP.
- Pointer arithmetic: 8-bit, wraps 8'hFF → 8'h00 on both write and read increment.
- Simultaneous events: START/STOP take priority over bit sampling. A START detected while in ACK or RDATA releases sda_oe in the same clk it is detected.
- Reset mid-transaction: sda_oe drops on the next clk, no wr_en, state IDLE. A transaction mid-flight on the bus is ignored until the next START.
- wr_en never asserts for the address byte, the sub-address byte, a partial byte, or a byte in a non-matching transaction.
- sda_oe is never asserted while the synchronized SCL is high, except when holding an ACK or read bit across the high phase.

Test Plan:
- Write: START, 0xE0, 0x0A, 0x55, 0x1F, STOP → four ACKs (sda_oe high during each 9th clock). wr_en pulses exactly twice: (0x0A,0x55) then (0x0B,0x1F). busy=0 after STOP.
- Address mismatch: START, 0xE2, 0x0A, 0x55, STOP → sda_oe stays 0 throughout, no wr_en, busy stays 0.
- Read with repeated START: write sub 0x10, then Sr, 0xE1, read 2 bytes (ACK first, NACK second), with the register model rd_data = rd_addr ^ 0xA5 → bus bytes 0xB5 then 0xB4. SDA released after the NACK, rd_addr=0x12.
- Wrap: START, 0xE0, 0xFF, 0x11, 0x22, STOP → wr_en at (0xFF,0x11) and (0x00,0x22).
- Abort: STOP after 5 bits of a data byte → no wr_en for that byte, state IDLE. The next full write succeeds.
- Reset mid-byte: assert rst for 1 clk during the 4th bit of a data byte → sda_oe=0, wr_en=0, rd_addr=0 next clk. The bus activity up to the next START is ignored, and a following write to 0x05 with 0x33 strobes (0x05,0x33).
